vedic_mul_seq_ctrl: RTL



---
 rtl/vedic_mul_seq_ctrl_if.sv | 29 ++
 rtl/vedic_mul_seq_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Handshake and shared-core bus for vedic_mul_seq_ctrl.
// master = the sequencing controller, slave = the operand/core/consumer environment.
interface vedic_mul_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int HALF = WIDTH / 2;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [HALF-1:0]      mul_a;
    logic [HALF-1:0]      mul_b;
    logic                 mul_en;
    logic [WIDTH-1:0]     mul_p;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;

    modport master (
        input  in_valid, a, b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, mul_en, out_valid, p
    );

    modport slave (
        output in_valid, a, b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, mul_en, out_valid, p
    );
endinterface

// File: rtl/vedic_mul_seq_ctrl.sv
// Sequences four HALF x HALF partial products through one shared Vedic core and accumulates a WIDTH x WIDTH product.
// Optional macro ZERO_SKIP_EN: zero operands bypass the partial-product sequence and go straight to DONE.
module vedic_mul_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vedic_mul_seq_ctrl_if.master  bus
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   p_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 mul_en_q;
    logic [HALF-1:0]      mul_a_q;
    logic [HALF-1:0]      mul_b_q;
    logic [2*WIDTH-1:0]   pp_ext;

    // Cross terms AH*BL and AL*BH share the same weight, so PP1 and PP2 use one shift.
    always_comb begin
        pp_ext = {{WIDTH{1'b0}}, bus.mul_p};
        acc_d  = acc_q;
        case (state_q)
            PP0:      acc_d = acc_q + pp_ext;
            PP1, PP2: acc_d = acc_q + (pp_ext << HALF);
            PP3:      acc_d = acc_q + (pp_ext << WIDTH);
            default:  acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef ZERO_SKIP_EN
                        if ((bus.a == '0) || (bus.b == '0)) begin
                            state_q     <= DONE;
                            p_q         <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q  <= PP0;
                            mul_en_q <= 1'b1;
                            mul_a_q  <= bus.a[HALF-1:0];
                            mul_b_q  <= bus.b[HALF-1:0];
                        end
`else
                        state_q  <= PP0;
                        mul_en_q <= 1'b1;
                        mul_a_q  <= bus.a[HALF-1:0];
                        mul_b_q  <= bus.b[HALF-1:0];
`endif
                    end
                end
                // Core halves are registered one state ahead so they line up with the state that consumes mul_p.
                PP0: begin
                    acc_q   <= acc_d;
                    state_q <= PP1;
                    mul_a_q <= a_q[WIDTH-1:HALF];
                    mul_b_q <= b_q[HALF-1:0];
                end
                PP1: begin
                    acc_q   <= acc_d;
                    state_q <= PP2;
                    mul_a_q <= a_q[HALF-1:0];
                    mul_b_q <= b_q[WIDTH-1:HALF];
                end
                PP2: begin
                    acc_q   <= acc_d;
                    state_q <= PP3;
                    mul_a_q <= a_q[WIDTH-1:HALF];
                    mul_b_q <= b_q[WIDTH-1:HALF];
                end
                PP3: begin
                    acc_q       <= acc_d;
                    p_q         <= acc_d;
                    out_valid_q <= 1'b1;
                    mul_en_q    <= 1'b0;
                    mul_a_q     <= '0;
                    mul_b_q     <= '0;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    mul_en_q    <= 1'b0;
                    mul_a_q     <= '0;
                    mul_b_q     <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.mul_en    = mul_en_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule
